// File: rtl/mul_result_stage.sv
// Result stage for a pipelined 32x32 multiplier: tracks issued tags alongside the
// multiplier, applies the MULHSU high-word correction and buffers results for writeback.
`timescale 1ns/1ps

module mul_result_stage #(
  parameter int MUL_LAT    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic        in_a_neg,
  input  logic [31:0] in_b,
  output logic        mul_is_unsigned,
  input  logic [63:0] mul_prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        busy
);

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             issue;
  logic             pop;
  logic             push;
  logic [CNT_W-1:0] occ_q;
  logic [CNT_W-1:0] fifo_count_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic [4:0]       fifo_rd   [FIFO_DEPTH];

  logic             tail_valid;
  mul_op_e          tail_op;
  logic [4:0]       tail_rd;
  logic             tail_a_neg;
  logic [31:0]      tail_b;
  logic [31:0]      result;

  // occ counts everything issued but not yet popped, so it bounds FIFO fill
  // before the product even exists; in_ready never sees out_ready.
  assign in_ready        = rst | (occ_q < DEPTH_C);
  assign issue           = in_valid & in_ready & ~rst;
  assign out_valid       = ~rst & (fifo_count_q != '0);
  assign pop             = out_valid & out_ready;
  assign busy            = ~rst & (occ_q != '0);
  assign out_data        = out_valid ? fifo_data[rd_ptr_q] : '0;
  assign out_rd          = out_valid ? fifo_rd[rd_ptr_q] : '0;
  assign mul_is_unsigned = in_op[1];
  assign push            = tail_valid;

  // The issue cycle is the first tag stage; the product is present in the last.
  generate
    if (MUL_LAT == 1) begin : g_no_pipe
      assign tail_valid = issue;
      assign tail_op    = mul_op_e'(in_op);
      assign tail_rd    = in_rd;
      assign tail_a_neg = in_a_neg;
      assign tail_b     = in_b;
    end else begin : g_pipe
      localparam int STAGES = MUL_LAT - 1;

      logic [STAGES-1:0] st_valid;
      mul_op_e           st_op    [STAGES];
      logic [4:0]        st_rd    [STAGES];
      logic              st_a_neg [STAGES];
      logic [31:0]       st_b     [STAGES];

      always_ff @(posedge clk) begin
        if (rst) begin
          st_valid <= '0;
        end else begin
          st_valid[0] <= issue;
          for (int k = 1; k < STAGES; k++) begin
            st_valid[k] <= st_valid[k-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        st_op[0]    <= mul_op_e'(in_op);
        st_rd[0]    <= in_rd;
        st_a_neg[0] <= in_a_neg;
        st_b[0]     <= in_b;
        for (int k = 1; k < STAGES; k++) begin
          st_op[k]    <= st_op[k-1];
          st_rd[k]    <= st_rd[k-1];
          st_a_neg[k] <= st_a_neg[k-1];
          st_b[k]     <= st_b[k-1];
        end
      end

      assign tail_valid = st_valid[STAGES-1];
      assign tail_op    = st_op[STAGES-1];
      assign tail_rd    = st_rd[STAGES-1];
      assign tail_a_neg = st_a_neg[STAGES-1];
      assign tail_b     = st_b[STAGES-1];
    end
  endgenerate

  // The multiplier runs MULHSU unsigned; a negative rs1 over-counts b * 2^32.
  always_comb begin
    result = mul_prod[63:32];
    case (tail_op)
      OP_MUL:    result = mul_prod[31:0];
      OP_MULHSU: result = mul_prod[63:32] - (tail_a_neg ? tail_b : 32'd0);
      default:   result = mul_prod[63:32];
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr_q] <= result;
      fifo_rd[wr_ptr_q]   <= tail_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      occ_q        <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
        fifo_count_q <= fifo_count_q + CNT_ONE;
      end else if (!push && pop) begin
        fifo_count_q <= fifo_count_q - CNT_ONE;
      end
      if (issue && !pop) begin
        occ_q <= occ_q + CNT_ONE;
      end else if (!issue && pop) begin
        occ_q <= occ_q - CNT_ONE;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (fifo_count_q == DEPTH_C)));

endmodule

// File: doc/mul_result_stage.md
MUL_RESULT_STAGE -- requirements
Module: mul_result_stage

Interface
REQ-001 The block SHALL have parameter MUL_LAT, default 3, giving the fixed cycle count from operand issue to a valid product at mul_prod (legal range 1-8).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the result buffer entry count (legal range 1-8).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset; reset is synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit, issue request.
REQ-006 The block SHALL have port in_ready, output, 1 bit, issue accept permitted.
REQ-007 The block SHALL have port in_op, input, 2 bits, selecting 00 MUL, 01 MULH, 10 MULHSU or 11 MULHU.
REQ-008 The block SHALL have port in_rd, input, 5 bits, the destination register tag.
REQ-009 The block SHALL have port in_a_neg, input, 1 bit, equal to rs1[31].
REQ-010 The block SHALL have port in_b, input, 32 bits, the rs2 value used for MULHSU correction.
REQ-011 The block SHALL have port mul_is_unsigned, output, 1 bit, the mode driven to the multiplier.
REQ-012 The block SHALL have port mul_prod, input, 64 bits, the multiplier product.
REQ-013 The block SHALL have port out_valid, output, 1 bit, result available.
REQ-014 The block SHALL have port out_ready, input, 1 bit, consumer accepts the result.
REQ-015 The block SHALL have port out_data, output, 32 bits, the writeback value.
REQ-016 The block SHALL have port out_rd, output, 5 bits, the writeback tag.
REQ-017 The block SHALL have port busy, output, 1 bit, indicating operations in flight or buffered.

Function
REQ-018 Issue SHALL occur in a cycle where in_valid and in_ready are both 1.
REQ-019 mul_is_unsigned SHALL be combinational from in_op: 0 for 00/01, 1 for 10/11.
REQ-020 On issue, op, rd, a_neg and b SHALL enter a MUL_LAT-stage tag pipeline with a valid bit; one issue per cycle is allowed.
REQ-021 Exactly MUL_LAT cycles after issue, the block SHALL sample mul_prod and push the corrected result and tag into the FIFO in that cycle.
REQ-022 The result SHALL be prod[31:0] for MUL and prod[63:32] for MULH and MULHU.
REQ-023 For MULHSU the result SHALL be (prod[63:32] - (a_neg ? b : 0)) mod 2^32, where prod is the unsigned product.
REQ-024 The block SHALL keep occ = in_flight + fifo_count; occ increments on issue, decrements on pop, and is unchanged when both occur in the same cycle.
REQ-025 in_ready SHALL be (occ < FIFO_DEPTH), decoded from registers only, with no combinational path from out_ready.
REQ-026 The FIFO SHALL never overflow; a push to a full FIFO is unreachable by construction and is asserted in verification.
REQ-027 out_valid SHALL be 1 when the FIFO is not empty; out_data and out_rd SHALL be the head entry; a pop occurs when out_valid and out_ready are both 1.
REQ-028 A simultaneous push and pop SHALL be legal at any occupancy, leaving fifo_count unchanged.
REQ-029 Results SHALL leave in issue order, and pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 With FIFO_DEPTH >= MUL_LAT+1 and out_ready held at 1, the block SHALL sustain one issue per cycle.
REQ-031 Head outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-032 busy SHALL be (occ != 0).

Reset
REQ-033 While rst=1, all tag-pipeline valid bits, occ, fifo_count and the FIFO pointers SHALL clear.
REQ-034 During and after reset, out_valid=0, out_data=0, out_rd=0, busy=0 and in_ready=1 SHALL hold.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight and buffered results.
REQ-036 Products arriving at mul_prod after reset for operations issued before it SHALL be ignored.

Verification
REQ-037 The bench SHALL model the multiplier as a MUL_LAT=3 pipeline and cover the scenarios in REQ-038 to REQ-043.
REQ-038 MUL, a=3, b=-2 (0xFFFFFFFE), rd=5 -> out_valid 3 cycles after issue, out_data=0xFFFFFFFA, out_rd=5.
REQ-039 MULH, a=b=-123 -> out_data=0x00000000; MUL with the same operands -> out_data=0x00003B19.
REQ-040 MULHSU, a=0xFFFFFFFF, b=2 -> mul_is_unsigned=1, unsigned product 0x1_FFFFFFFE, out_data=0xFFFFFFFF; MULHU, a=b=0xFFFFFFFF -> out_data=0xFFFFFFFE.
REQ-041 With out_ready=0, five back-to-back issue attempts -> in_ready falls after the 4th accept and the 5th is held; after out_ready is raised, results appear in issue order with no loss or duplication.
REQ-042 With out_ready=1, ten consecutive issues -> ten results on ten consecutive cycles starting at cycle 3, and in_ready stays 1 throughout.
REQ-043 With two operations issued, rst pulsed for 1 cycle at cycle 2 -> no out_valid occurs afterwards, and busy=0 and in_ready=1 in the cycle after reset.
